// File: rtl/riscv_pkg.sv
// Shared RV32I types for the ID stage and the ID/EX register.
// Field order of ctrl_s/data_s is fixed here; id_ex_reg relies on it.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;

  typedef enum logic [1:0] {SRCA_REG, SRCA_PC, SRCA_ZERO} src_a_e;

  typedef struct packed {
    logic        RegWrite;
    result_src_e ResultSrc;
    logic        MemWrite;
    logic        Jump;
    logic        Jalr;
    logic        Branch;
    logic [2:0]  BranchOp;
    alu_op_e     ALUControl;
    src_a_e      ALUSrcA;
    logic        ALUSrc;
    imm_src_e    ImmSrc;
  } ctrl_s;

  typedef struct packed {
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic [4:0]      Rd;
  } data_s;

  // alt selects SUB (funct3 000) or SRA (funct3 101); caller decides when it applies.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/flop_en_rst_cl.sv
// Register with synchronous active-low reset, synchronous clear and load enable.
// Priority: reset > clear > enable.
module flop_en_rst_cl #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst)     q_q <= RESET_VAL;
    else if (clr) q_q <= RESET_VAL;
    else if (en)  q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile.sv
// 32 x XLEN register file, 2 combinational reads, 1 write, write-first bypass.
// x0 is hard-wired to zero; active-low reset clears x1..x31 and drops a same-cycle write.
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [1:31];

  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (!rst)                          regs_q[i] <= '0;
      else if (we && waddr == 5'(i))     regs_q[i] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    if (a == 5'd0)                 return '0;
    else if (we && waddr == a)     return wdata;
    else                           return regs_q[a];
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file, main/ALU decoder and
// immediate generator feeding the ID/EX register.
module id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output ctrl_s           ctrl_d,
  output data_s           data_d,
  output logic            IllegalD
);

  localparam int IFID_W = 32 + 2 * XLEN;

  logic [IFID_W-1:0] ifid_q;
  logic [31:0]       instr_d;
  logic [XLEN-1:0]   pc_d, pc_plus4_d;
  logic [XLEN-1:0]   rd1, rd2, imm_ext;
  ctrl_s             ctrl_dec;
  logic              legal;

  flop_en_rst_cl #(
    .WIDTH     (IFID_W),
    .RESET_VAL ({NOP_INSN, {(2 * XLEN){1'b0}}})
  ) u_ifid (
    .clk (clk),
    .rst (rst),
    .en  (~StallD),
    .clr (FlushD),
    .d   ({InstrF, PCF, PCPlus4F}),
    .q   (ifid_q)
  );

  assign {instr_d, pc_d, pc_plus4_d} = ifid_q;

  regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (instr_d[19:15]),
    .raddr2 (instr_d[24:20]),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = instr_d[14:12];
  assign f7 = instr_d[31:25];

  always_comb begin
    ctrl_dec = '0;
    legal    = 1'b1;
    case (instr_d[6:0])
      OP_R: begin
        ctrl_dec.RegWrite   = 1'b1;
        ctrl_dec.ALUControl = alu_from_funct3(f3, f7[5]);
        legal = (f7 == 7'b0000000) ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OP_I: begin
        ctrl_dec.RegWrite   = 1'b1;
        ctrl_dec.ALUSrc     = 1'b1;
        ctrl_dec.ImmSrc     = IMM_I;
        // Only the right shift borrows funct7[5]; ADDI must never turn into SUB.
        ctrl_dec.ALUControl = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      OP_LOAD: begin
        ctrl_dec.RegWrite  = 1'b1;
        ctrl_dec.ALUSrc    = 1'b1;
        ctrl_dec.ResultSrc = RES_MEM;
        ctrl_dec.ImmSrc    = IMM_I;
        legal = (f3 == 3'b010);
      end
      OP_STORE: begin
        ctrl_dec.MemWrite = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.ImmSrc   = IMM_S;
        legal = (f3 == 3'b010);
      end
      OP_BRANCH: begin
        ctrl_dec.Branch     = 1'b1;
        ctrl_dec.BranchOp   = f3;
        ctrl_dec.ImmSrc     = IMM_B;
        ctrl_dec.ALUControl = ALU_SUB;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_JAL: begin
        ctrl_dec.RegWrite  = 1'b1;
        ctrl_dec.Jump      = 1'b1;
        ctrl_dec.ResultSrc = RES_PC4;
        ctrl_dec.ImmSrc    = IMM_J;
        ctrl_dec.ALUSrcA   = SRCA_PC;
        ctrl_dec.ALUSrc    = 1'b1;
      end
      OP_JALR: begin
        ctrl_dec.RegWrite  = 1'b1;
        ctrl_dec.Jump      = 1'b1;
        ctrl_dec.Jalr      = 1'b1;
        ctrl_dec.ResultSrc = RES_PC4;
        ctrl_dec.ImmSrc    = IMM_I;
        ctrl_dec.ALUSrc    = 1'b1;
        legal = (f3 == 3'b000);
      end
      OP_LUI: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ImmSrc   = IMM_U;
        ctrl_dec.ALUSrcA  = SRCA_ZERO;
        ctrl_dec.ALUSrc   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ImmSrc   = IMM_U;
        ctrl_dec.ALUSrcA  = SRCA_PC;
        ctrl_dec.ALUSrc   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (ctrl_dec.ImmSrc)
      IMM_I:   imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
      IMM_S:   imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B:   imm_ext = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                          instr_d[30:25], instr_d[11:8], 1'b0};
      IMM_U:   imm_ext = {instr_d[31:12], 12'b0};
      IMM_J:   imm_ext = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                          instr_d[20], instr_d[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // An illegal instruction leaves the stage as a bubble; the data path stays live.
  assign IllegalD = ~legal;
  assign ctrl_d   = legal ? ctrl_dec : '0;

  always_comb begin
    data_d         = '0;
    data_d.RD1     = rd1;
    data_d.RD2     = rd2;
    data_d.PC      = pc_d;
    data_d.ImmExt  = imm_ext;
    data_d.PCPlus4 = pc_plus4_d;
    data_d.Rs1     = instr_d[19:15];
    data_d.Rs2     = instr_d[24:20];
    data_d.Rd      = instr_d[11:7];
  end

endmodule
